tdes_ctrl: RTL and testbench
============================

Name: tdes_ctrl

Overview:
Sequencer that runs Triple-DES (EDE, keying option 1/2) on one pipelined des core instance by issuing each block through the core three times with the correct sub-key and direction per pass. It sits between a valid/accept block source and the des core, holds one block in flight, and presents the result on a valid/ready output. A single-DES bypass mode uses k1 only and makes one pass.

Parameters:
DES_LATENCY, 19, cycles from des_valid_o sampled high to the matching des_valid_i; used for the latency check.

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-low
mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on accept
tdes_en_i  in  1  1 = 3DES EDE, 0 = single DES with k1; sampled on accept
key_i  in  [0:191]  {k1, k2, k3}, each 64 bit; sampled on accept
data_i  in  [0:63]  input block
valid_i  in  1  input block valid
accept_o  out  1  controller can take a block
data_o  out  [0:63]  result block
valid_o  out  1  result valid, held until ready_i
ready_i  in  1  downstream takes result
busy_o  out  1  block in flight or result pending
err_o  out  1  sticky protocol error
des_mode_o  out  1  to des core mode_i
des_key_o  out  [0:63]  to des core key_i
des_data_o  out  [0:63]  to des core data_i
des_valid_o  out  1  to des core valid_i
des_data_i  in  [0:63]  from des core data_o
des_valid_i  in  1  from des core valid_o

Behaviour:
- Reset (async, reset_i=0): state IDLE. All outputs 0 except accept_o=1. Captured key, mode, data and the cycle counter are cleared. err_o is cleared only by reset.
- States: IDLE, ISSUE, WAIT, DONE. Pass index p is 1..3.
- IDLE: accept_o=1. When valid_i=1, capture key_i, mode_i, tdes_en_i and data_i, set p=1, and go to ISSUE. accept_o is 0 in every other state.
- ISSUE lasts one cycle:
  - des_valid_o=1, with des_data_o, des_key_o and des_mode_o driven from registers.
  - Clear the counter, then go to WAIT.
- Pass schedule, by pass p:
  - Encrypt: p1 = (k1, E), p2 = (k2, D), p3 = (k3, E).
  - Decrypt: p1 = (k3, D), p2 = (k2, E), p3 = (k1, D).
  - tdes_en=0: a single pass with k1 and mode as captured.
- des_data_o: captured data_i for p1; the previous des_data_i for p2 and p3.
- des_key_o, des_data_o and des_mode_o hold their last values outside ISSUE. des_valid_o is 1 only in ISSUE.
- WAIT: the counter increments every cycle.
  - des_valid_i with counter == DES_LATENCY-1: latch des_data_i.
    - If this is the last pass: load data_o, go to DONE (valid_o=1 next cycle).
    - Otherwise: p=p+1, go to ISSUE.
  - des_valid_i with any other counter value, or counter reaching DES_LATENCY with no des_valid_i: set err_o=1, drop the block, go to IDLE.
- Latency at DES_LATENCY=19, measured from the valid_i&accept_o cycle (cycle 0) to valid_o=1:
  - 3DES: issues in cycles 1, 21 and 41; returns in cycles 20, 40 and 60; valid_o in cycle 61.
  - Single DES: valid_o in cycle 21.
- DONE:
  - valid_o=1 and data_o stable until ready_i=1.
  - On valid_o&ready_i, go to IDLE; accept_o=1 the next cycle. There is no same-cycle pass-through.
- busy_o = (state != IDLE).
- des_valid_i in IDLE or DONE sets err_o and is otherwise ignored. Outputs are unaffected.
- valid_i while accept_o=0 is ignored; the source must hold it.
- Reset mid-operation: the block is dropped immediately and no result is produced.
  - The des core shares reset_i.
  - A stray completion after reset still sets err_o per the rule above.
- Bit order is MSB-first [0:n], matching the des core. k1 is key_i[0:63], k2 is key_i[64:127], k3 is key_i[128:191].

Test Plan:
1. Single DES encrypt:
   - Stimulus: tdes_en=0, mode=0, k1=133457799BBCDFF1, data=0123456789ABCDEF.
   - Required: data_o=85E813540F0AB405, valid_o in cycle 21, exactly one des_valid_o pulse.
2. Degenerate 3DES encrypt:
   - Stimulus: tdes_en=1, mode=0, k1=k2=k3=133457799BBCDFF1, data=0123456789ABCDEF.
   - Required: data_o=85E813540F0AB405, valid_o in cycle 61, des_valid_o in cycles 1, 21 and 41, des_mode_o 0/1/0.
3. 3DES round trip:
   - Stimulus: encrypt with k1=0123456789ABCDEF, k2=23456789ABCDEF01, k3=456789ABCDEF0123 and data=5468652071756663; feed the result back with mode=1.
   - Required: the decrypt returns 5468652071756663; the decrypt pass keys are k3, k2, k1.
4. Output backpressure:
   - Stimulus: hold ready_i=0 for 10 cycles after valid_o, then assert it; hold valid_i=1 with a second block throughout.
   - Required: data_o stable and accept_o=0 until the handshake, then accept_o=1 the following cycle and the second block is accepted.
5. Latency violation:
   - Stimulus: core model returns des_valid_i at 18 cycles, or not at all.
   - Required: err_o=1 sticky, return to IDLE, no valid_o.
   - Also: a stray des_valid_i in IDLE sets err_o.
6. Reset mid-block:
   - Stimulus: deassert reset_i during WAIT of pass 2.
   - Required: all outputs 0 and accept_o=1 asynchronously; err_o cleared; a subsequent block completes correctly.

Source files
------------

// File: rtl/tdes_ctrl.sv
// Triple-DES EDE sequencer: one block in flight, three passes through a shared DES core.
// Latency passes*(DES_LATENCY+1)+1 cycles to valid_o. Result held until ready_i; accept_o low while busy.
module tdes_ctrl #(
    parameter int DES_LATENCY = 19
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         mode_i,
    input  logic         tdes_en_i,
    input  logic [0:191] key_i,
    input  logic [0:63]  data_i,
    input  logic         valid_i,
    output logic         accept_o,
    output logic [0:63]  data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         busy_o,
    output logic         err_o,
    output logic         des_mode_o,
    output logic [0:63]  des_key_o,
    output logic [0:63]  des_data_o,
    output logic         des_valid_o,
    input  logic [0:63]  des_data_i,
    input  logic         des_valid_i
);
    localparam int CW = $clog2(DES_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic        mode;
        logic [0:63] key;
    } pass_cfg_t;

    // EDE schedule: middle pass flips direction; decrypt walks the keys k3,k2,k1.
    function automatic pass_cfg_t pass_cfg(input logic [0:191] key, input logic dec,
                                           input logic tdes, input logic [1:0] p);
        pass_cfg_t c;
        if (!tdes) begin
            c.mode = dec;
            c.key  = key[0:63];
        end else begin
            c.mode = dec ^ (p == 2'd2);
            if (p == 2'd2)
                c.key = key[64:127];
            else if ((p == 2'd1) ^ dec)
                c.key = key[0:63];
            else
                c.key = key[128:191];
        end
        return c;
    endfunction

    state_t          state_q;
    logic [0:191]    key_q;
    logic            mode_q;
    logic            tdes_q;
    logic [1:0]      pass_q;
    logic [CW-1:0]   cnt_q;
    pass_cfg_t       cfg_first;
    pass_cfg_t       cfg_next;
    logic            last_pass;
    logic            lat_ok;
    logic            lat_over;

    assign cfg_first = pass_cfg(key_i, mode_i, tdes_en_i, 2'd1);
    assign cfg_next  = pass_cfg(key_q, mode_q, tdes_q, pass_q + 2'd1);
    assign last_pass = !tdes_q || (pass_q == 2'd3);
    assign lat_ok    = (cnt_q == CW'(DES_LATENCY - 1));
    assign lat_over  = (cnt_q == CW'(DES_LATENCY));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            key_q       <= '0;
            mode_q      <= 1'b0;
            tdes_q      <= 1'b0;
            pass_q      <= 2'd0;
            cnt_q       <= '0;
            accept_o    <= 1'b1;
            data_o      <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            des_mode_o  <= 1'b0;
            des_key_o   <= '0;
            des_data_o  <= '0;
            des_valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (des_valid_i)
                        err_o <= 1'b1;
                    if (valid_i) begin
                        key_q       <= key_i;
                        mode_q      <= mode_i;
                        tdes_q      <= tdes_en_i;
                        pass_q      <= 2'd1;
                        des_mode_o  <= cfg_first.mode;
                        des_key_o   <= cfg_first.key;
                        des_data_o  <= data_i;
                        des_valid_o <= 1'b1;
                        accept_o    <= 1'b0;
                        busy_o      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    des_valid_o <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (des_valid_i && lat_ok) begin
                        if (last_pass) begin
                            data_o  <= des_data_i;
                            valid_o <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            pass_q      <= pass_q + 2'd1;
                            des_mode_o  <= cfg_next.mode;
                            des_key_o   <= cfg_next.key;
                            des_data_o  <= des_data_i;
                            des_valid_o <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end else if (des_valid_i || lat_over) begin
                        // Core out of step with us: drop the block rather than guess.
                        err_o    <= 1'b1;
                        accept_o <= 1'b1;
                        busy_o   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (des_valid_i)
                        err_o <= 1'b1;
                    if (ready_i) begin
                        valid_o  <= 1'b0;
                        accept_o <= 1'b1;
                        busy_o   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdes_ctrl.sv
// Bench for tdes_ctrl: behavioural DES core with adjustable return latency, directed vectors.
module tb_tdes_ctrl;
    localparam int LAT = 19;

    localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [0:63] des_ref(input logic [0:63] key, input logic [0:63] din,
                                            input logic dec);
        logic [0:55]  cd;
        logic [0:47]  ks [16];
        logic [0:47]  x;
        logic [0:63]  ipd, pre, dout;
        logic [0:31]  l, r, t, so, f;
        logic [5:0]   six;
        logic [255:0] sbt;
        int           ent;
        for (int i = 0; i < 56; i++) cd[i] = key[PC1[i]-1];
        for (int rr = 0; rr < 16; rr++) begin
            for (int s = 0; s < ((rr < 2 || rr == 8 || rr == 15) ? 1 : 2); s++)
                cd = {cd[1:27], cd[0], cd[29:55], cd[28]};
            for (int i = 0; i < 48; i++) ks[rr][i] = cd[PC2[i]-1];
        end
        for (int i = 0; i < 64; i++) ipd[i] = din[IP[i]-1];
        l = ipd[0:31];
        r = ipd[32:63];
        for (int rr = 0; rr < 16; rr++) begin
            for (int i = 0; i < 48; i++)
                x[i] = r[(4*(i/6) + i%6 + 31) % 32] ^ ks[dec ? 15-rr : rr][i];
            for (int b = 0; b < 8; b++) begin
                six = x[6*b +: 6];
                ent = 16*{six[5], six[0]} + six[4:1];
                sbt = SB[b];
                so[4*b +: 4] = sbt[255 - 4*ent -: 4];
            end
            for (int i = 0; i < 32; i++) f[i] = so[P[i]-1];
            t = l ^ f;
            l = r;
            r = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) dout[IP[i]-1] = pre[i];
        return dout;
    endfunction

    function automatic logic [0:63] tdes_ref(input logic [0:191] key, input logic [0:63] din);
        return des_ref(key[128:191], des_ref(key[64:127], des_ref(key[0:63], din, 1'b0), 1'b1), 1'b0);
    endfunction

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         mode_i = 1'b0, tdes_en_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic [0:191] key_i = '0;
    logic [0:63]  data_i = '0;
    logic         accept_o, valid_o, busy_o, err_o, des_mode_o, des_valid_o;
    logic [0:63]  data_o, des_key_o, des_data_o;
    logic [0:63]  des_data_i = '0;
    logic         des_valid_i = 1'b0;

    tdes_ctrl #(.DES_LATENCY(LAT)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i), .tdes_en_i(tdes_en_i),
        .key_i(key_i), .data_i(data_i), .valid_i(valid_i), .accept_o(accept_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
        .err_o(err_o), .des_mode_o(des_mode_o), .des_key_o(des_key_o),
        .des_data_o(des_data_o), .des_valid_o(des_valid_o),
        .des_data_i(des_data_i), .des_valid_i(des_valid_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Core model and issue monitor; core_lat == 0 means the core never answers.
    int          core_lat = LAT;
    logic        force_stray = 1'b0;
    logic        pend = 1'b0;
    int          due = 0;
    logic [0:63] pres = '0;
    int          n_iss = 0;
    int          iss_cyc [256];
    logic        iss_mode [256];
    logic [0:63] iss_key [256];
    logic [0:63] iss_data [256];

    always @(negedge clk_i) begin
        des_valid_i = force_stray;
        if (!reset_i) pend = 1'b0;
        if (pend && cyc == due) begin
            des_valid_i = 1'b1;
            des_data_i  = pres;
            pend        = 1'b0;
        end
        if (des_valid_o && n_iss < 256) begin
            iss_cyc[n_iss]  = cyc;
            iss_mode[n_iss] = des_mode_o;
            iss_key[n_iss]  = des_key_o;
            iss_data[n_iss] = des_data_o;
            n_iss++;
            if (core_lat > 0) begin
                pend = 1'b1;
                due  = cyc + core_lat;
                pres = des_ref(des_key_o, des_data_o, des_mode_o);
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;
    int t0 = 0;
    int ib = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic start_block(input logic tdes, input logic dec, input logic [0:191] key,
                               input logic [0:63] din);
        int k;
        @(negedge clk_i);
        tdes_en_i = tdes;
        mode_i    = dec;
        key_i     = key;
        data_i    = din;
        valid_i   = 1'b1;
        k = 0;
        while (!accept_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        t0 = cyc;
        ib = n_iss;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_result(output logic [0:63] res, output int lat);
        int k;
        k = 0;
        while (!valid_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        lat = valid_o ? cyc - t0 : -1;
        res = data_o;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic run_bad(output logic seen_v);
        seen_v = 1'b0;
        repeat (60) begin
            @(negedge clk_i);
            seen_v |= valid_o;
        end
    endtask

    localparam logic [0:63] KD  = 64'h133457799BBCDFF1;
    localparam logic [0:63] PD  = 64'h0123456789ABCDEF;
    localparam logic [0:63] CD  = 64'h85E813540F0AB405;
    localparam logic [0:63] K1  = 64'h0123456789ABCDEF;
    localparam logic [0:63] K2  = 64'h23456789ABCDEF01;
    localparam logic [0:63] K3  = 64'h456789ABCDEF0123;
    localparam logic [0:63] PT  = 64'h5468652071756663;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [0:63] res, ct, got;
        int          lat, bad;
        logic        seen_v;

        #2 reset_i = 1'b0;
        #1;
        check("rst_ctl", {accept_o, busy_o, valid_o, err_o, des_valid_o, des_mode_o}, 6'b100000);
        check("rst_dat", data_o | des_key_o | des_data_o, 64'h0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;

        // Single DES encrypt
        start_block(1'b0, 1'b0, {KD, 128'h0}, PD);
        wait_result(res, lat);
        check("t1_data", res, CD);
        check("t1_lat", 64'(lat), 64'd21);
        check("t1_npass", 64'(n_iss - ib), 64'd1);
        check("t1_key", iss_key[ib], KD);

        // Degenerate 3DES: E-D-E with one key collapses to single DES
        start_block(1'b1, 1'b0, {KD, KD, KD}, PD);
        wait_result(res, lat);
        check("t2_data", res, CD);
        check("t2_lat", 64'(lat), 64'd61);
        check("t2_iss_cyc", {16'(iss_cyc[ib]-t0), 16'(iss_cyc[ib+1]-t0), 16'(iss_cyc[ib+2]-t0)},
              {16'd1, 16'd21, 16'd41});
        check("t2_modes", {iss_mode[ib], iss_mode[ib+1], iss_mode[ib+2]}, 3'b010);

        // 3DES round trip
        start_block(1'b1, 1'b0, {K1, K2, K3}, PT);
        wait_result(ct, lat);
        check("t3_enc", ct, tdes_ref({K1, K2, K3}, PT));
        check("t3_p2_data", iss_data[ib+1], des_ref(K1, PT, 1'b0));
        check("t3_enc_keys", (iss_key[ib] ^ K1) | (iss_key[ib+1] ^ K2) | (iss_key[ib+2] ^ K3), 64'h0);
        start_block(1'b1, 1'b1, {K1, K2, K3}, ct);
        wait_result(res, lat);
        check("t3_dec", res, PT);
        check("t3_dec_k3", iss_key[ib], K3);
        check("t3_dec_k2", iss_key[ib+1], K2);
        check("t3_dec_k1", iss_key[ib+2], K1);
        check("t3_dec_modes", {iss_mode[ib], iss_mode[ib+1], iss_mode[ib+2]}, 3'b101);

        // Output backpressure with a second block waiting
        @(negedge clk_i);
        tdes_en_i = 1'b0; mode_i = 1'b0; key_i = {K2, 128'h0}; data_i = PT; valid_i = 1'b1;
        @(negedge clk_i);
        key_i = {K3, 128'h0}; data_i = PD;
        bad = 0;
        while (!valid_o && bad < 200) begin
            @(negedge clk_i);
            bad++;
        end
        got = data_o;
        check("t4_data_a", got, des_ref(K2, PT, 1'b0));
        bad = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (data_o !== got || accept_o !== 1'b0 || valid_o !== 1'b1) bad++;
        end
        check("t4_hold", 64'(bad), 64'd0);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("t4_accept", {accept_o, valid_o}, 2'b10);
        t0 = cyc;
        ib = n_iss;
        @(negedge clk_i);
        valid_i = 1'b0;
        check("t4_b_taken", {busy_o, accept_o}, 2'b10);
        wait_result(res, lat);
        check("t4_data_b", res, des_ref(K3, PD, 1'b0));
        check("t4_lat_b", 64'(lat), 64'd21);

        // Early return, no return, stray return
        do_reset();
        core_lat = LAT - 1;
        start_block(1'b1, 1'b0, {K1, K2, K3}, PT);
        run_bad(seen_v);
        check("t5_early", {err_o, seen_v, accept_o, busy_o}, 4'b1010);
        do_reset();
        core_lat = 0;
        start_block(1'b1, 1'b0, {K1, K2, K3}, PT);
        run_bad(seen_v);
        check("t5_missing", {err_o, seen_v, accept_o, busy_o}, 4'b1010);
        do_reset();
        core_lat = LAT;
        check("t5_rst_err", 64'(err_o), 64'd0);
        @(posedge clk_i);
        force_stray = 1'b1;
        @(posedge clk_i);
        force_stray = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("t5_stray", {err_o, accept_o, valid_o, busy_o}, 4'b1100);
        start_block(1'b0, 1'b0, {KD, 128'h0}, PD);
        wait_result(res, lat);
        check("t5_after_data", res, CD);
        check("t5_sticky", 64'(err_o), 64'd1);

        // Reset during pass 2
        start_block(1'b1, 1'b0, {K1, K2, K3}, PT);
        bad = 0;
        while (n_iss - ib < 2 && bad < 100) begin
            @(negedge clk_i);
            bad++;
        end
        repeat (5) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("t6_ctl", {accept_o, busy_o, valid_o, err_o, des_valid_o, des_mode_o}, 6'b100000);
        check("t6_dat", data_o | des_key_o | des_data_o, 64'h0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        start_block(1'b1, 1'b0, {K1, K2, K3}, PT);
        wait_result(res, lat);
        check("t6_data", res, tdes_ref({K1, K2, K3}, PT));
        check("t6_lat_err", {16'(lat), 16'(err_o)}, {16'd61, 16'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
